// File: rtl/bw_seq_multiplier_pkg.sv
// bw_mult_pkg: shared types and constants for the sequential Baugh-Wooley multiplier
package bw_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [63:0] bw_correction(int width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction
  function automatic int cnt_width(int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/bw_seq_multiplier_if.sv
// bw_seq_multiplier_if: operand and product valid/ready handshakes
interface bw_seq_multiplier_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic signed_mode;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] p;
  modport master(output in_valid, a, b, signed_mode, out_ready, input in_ready, out_valid, p);
  modport slave(input in_valid, a, b, signed_mode, out_ready, output in_ready, out_valid, p);
endinterface

// File: rtl/bw_seq_multiplier_pp_row.sv
// bw_pp_row: one Baugh-Wooley partial-product row, unshifted
module bw_pp_row import bw_mult_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic b_bit,
  input  logic [cnt_width(WIDTH)-1:0] idx,
  input  logic signed_mode,
  output logic [WIDTH:0] row
);
  localparam int CW = cnt_width(WIDTH);
  logic last_row;
  // invert the bits where exactly one of row/column is the sign position
  always_comb begin
    row = '0;
    last_row = idx == CW'(WIDTH - 1);
    for (int j = 0; j < WIDTH; j++)
      row[j] = (a[j] & b_bit) ^ (signed_mode & (last_row ^ (j == WIDTH - 1)));
  end
endmodule

// File: rtl/bw_seq_multiplier.sv
// bw_seq_multiplier: one partial-product row per clock, shift-accumulate multiplier
module bw_seq_multiplier import bw_mult_pkg::*; #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  bw_seq_multiplier_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic sm_q;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc, sum, p_q;
  logic [WIDTH:0] row;
  logic in_ready, take, last;
  bw_pp_row #(.WIDTH(WIDTH)) u_row (
    .a(a_q),
    .b_bit(b_q[cnt]),
    .idx(cnt),
    .signed_mode(sm_q),
    .row(row)
  );
  // handshake decode, next state and the running sum with the current row
  always_comb begin
    in_ready = state == IDLE || (state == DONE && bus.out_ready);
    take = bus.in_valid && in_ready;
    last = cnt == CW'(WIDTH - 1);
    sum = acc + (PW'(row) << cnt);
    state_nxt = take ? RUN :
                (state == RUN && last) ? DONE :
                (state == DONE && bus.out_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // operand latch, row counter, accumulator and product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sm_q <= 1'b0;
      cnt <= '0;
      acc <= '0;
      p_q <= '0;
    end else if (take) begin
      a_q <= bus.a;
      b_q <= bus.b;
      sm_q <= bus.signed_mode;
      cnt <= '0;
      acc <= bus.signed_mode ? PW'(bw_correction(WIDTH)) : '0;
    end else if (state == RUN) begin
      acc <= sum;
      cnt <= cnt + CW'(1);
      if (last) p_q <= sum;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = state == DONE;
  assign bus.p = p_q;
endmodule

// File: doc/bw_seq_multiplier.md
# bw_seq_multiplier

Sequential, parametrised Baugh-Wooley multiplier for the IIR filter datapath. It replaces the fixed 4-bit combinational array with a WIDTH-generic shift-accumulate engine. Each clock it adds one Baugh-Wooley partial-product row. It supports two's-complement and unsigned operands, selected per transaction. It sits between the coefficient/sample registers and the filter accumulator, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement (Baugh-Wooley); 0 = unsigned. Sampled with the operands.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes the product this cycle.
- p  out  2*WIDTH  product; two's-complement when signed_mode = 1.

## Operation
- FSM states:
  - IDLE → RUN on an input handshake (in_valid && in_ready).
  - RUN → DONE after row WIDTH-1 has been added.
  - DONE → IDLE on out_ready, or DONE → RUN when out_ready and an input handshake occur in the same cycle.
- in_ready = (state == IDLE) || (state == DONE && out_ready). Back-to-back transactions need no idle bubble.
- On acceptance, latch a, b and signed_mode into internal registers. Later input changes have no effect on that transaction.
- On acceptance, preset the accumulator (2*WIDTH bits, wraps mod 2^(2*WIDTH)):
  - signed_mode = 1: 2^WIDTH + 2^(2*WIDTH-1), the Baugh-Wooley correction constant.
  - signed_mode = 0: 0.
- Row i (i = 0..WIDTH-1) is added in RUN cycle i. The row is the bits pp[j] = a[j] & b[i], shifted left by i.
- In signed_mode, invert pp[j] when exactly one of i, j equals WIDTH-1; pp[WIDTH-1] of row WIDTH-1 is not inverted.
- Row counter: clog2(WIDTH) bits, cleared on acceptance.
- p register:
  - Loaded from the accumulator on the RUN → DONE transition.
  - Holds its value otherwise, including after the output handshake and until the next result is loaded.
- out_valid = (state == DONE).
- Reset (asynchronous, at any time, including mid-RUN):
  - state = IDLE, in_ready = 1, out_valid = 0, p = 0.
  - Accumulator and counter cleared; any in-flight transaction is discarded.

## Timing
- Latency: an input handshake at clock edge E0 gives out_valid = 1 after edge E0+WIDTH.
- Throughput:
  - With out_ready held high: one product per WIDTH+1 cycles.
  - Under backpressure: the block stalls in DONE indefinitely. p and out_valid stay stable.
- in_ready is combinational only from state and out_ready; no path from in_valid to in_ready.
- p is registered; no combinational path from inputs to p.
- Simultaneous output and input handshake in DONE: the old product is consumed and the new operands are latched on the same edge. The next out_valid follows WIDTH edges later.

## Structure
- Package bw_mult_pkg:
  - state enum {IDLE, RUN, DONE};
  - function bw_correction(width), returning the preset constant;
  - function for the row-counter width.
- Sub-module bw_pp_row (combinational, parametrised by WIDTH):
  - inputs: latched a, one bit b[i], row index, signed_mode;
  - output: the WIDTH+1-bit partial-product row with Baugh-Wooley inversions applied.
- The top level holds the FSM, operand registers, counter, accumulator, shifter and output register.

## Test plan
- WIDTH=4, signed: a=4'h8, b=4'h8 (-8 × -8) → p=8'h40 after 4 cycles.
- WIDTH=8:
  - signed, a=8'h80, b=8'h7F → p=16'hC080 (-16256).
  - unsigned, a=b=8'hFF → p=16'hFE01 (65025).
- WIDTH=8, out_ready low for 5 cycles after out_valid:
  - p and out_valid hold, and in_ready = 0.
  - Operands changed during the stall do not affect p.
- Back-to-back, out_ready tied high, three transactions (3×5, -1×-1 signed, 0×255):
  - in_ready is asserted in each DONE cycle;
  - products are 15, 1, 0, spaced WIDTH+1 cycles apart.
- Assert rst_n low asynchronously in RUN cycle 3:
  - out_valid = 0, p = 0 and in_ready = 1 immediately.
  - A new transaction issued after reset returns the correct product.
- Randomised signed/unsigned sweep for WIDTH = 4, 8, 16 against a golden a*b model, mod 2^(2*WIDTH).
